// File: rtl/lsu_ext_port.sv
// Load/store unit in front of the data RAM ext port: one request at a time,
// alignment check, byte-enable generation, load extension, one-cycle response.
module lsu_ext_port #(
    parameter int ADDR_W       = 32,
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_stop,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_misalign,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_ram_be_n,
    output logic              ext_ram_wen,
    output logic [63:0]       ext_ram_write_data,
    input  logic [63:0]       ext_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] CAPT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic              wen_q;
    logic              uns_q;
    logic              mis_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rdata_q;
    logic [7:0]        be_q;

    logic              handshake;
    logic              misalign;
    logic [7:0]        be_base;
    logic              in_issue;

    function automatic logic [63:0] mask_to_size(input logic [1:0] size, input logic [63:0] d);
        case (size)
            2'd0:    mask_to_size = {56'd0, d[7:0]};
            2'd1:    mask_to_size = {48'd0, d[15:0]};
            2'd2:    mask_to_size = {32'd0, d[31:0]};
            default: mask_to_size = d;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [1:0] size, input logic uns, input logic [63:0] d);
        case (size)
            2'd0:    extend = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
            2'd1:    extend = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'd2:    extend = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    assign req_ready = (state == IDLE) && !mem_stop;
    assign handshake = req_valid && req_ready;

    always_comb begin
        be_base  = 8'h01;
        misalign = 1'b0;
        case (req_size)
            2'd0: be_base = 8'h01;
            2'd1: begin
                be_base  = 8'h03;
                misalign = req_addr[0];
            end
            2'd2: begin
                be_base  = 8'h0F;
                misalign = (req_addr[1:0] != 2'd0);
            end
            default: begin
                be_base  = 8'hFF;
                misalign = (req_addr[2:0] != 3'd0);
            end
        endcase
        if (!MISALIGN_CHK) begin
            misalign = 1'b0;
        end
    end

    // The RAM only ever sees a live strobe while in ISSUE; everywhere else the
    // port is quiet so a stalled or reset pipeline can never write by accident.
    assign in_issue           = (state == ISSUE);
    assign ext_addr           = in_issue ? addr_q  : '0;
    assign ext_ram_be_n       = in_issue ? be_q    : 8'h00;
    assign ext_ram_wen        = in_issue && wen_q;
    assign ext_ram_write_data = in_issue ? wdata_q : 64'd0;

    assign resp_valid    = (state == RESP);
    assign resp_misalign = (state == RESP) && mis_q;
    assign resp_rdata    = rdata_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            be_q    <= 8'h00;
        end else if (!mem_stop) begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        wen_q   <= req_wen;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= mask_to_size(req_size, req_wdata);
                        be_q    <= be_base << req_addr[2:0];
                        mis_q   <= misalign;
                        if (misalign) begin
                            rdata_q <= 64'd0;
                            state   <= RESP;
                        end else begin
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (wen_q) begin
                        rdata_q <= 64'd0;
                        state   <= RESP;
                    end else begin
                        state   <= CAPT;
                    end
                end
                CAPT: begin
                    rdata_q <= extend(size_q, uns_q, ext_data);
                    state   <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ext_port.sv
// Directed bench for lsu_ext_port with a byte-lane RAM model; a second
// instance with the alignment check disabled shares the request inputs.
module tb_lsu_ext_port;

    logic        clk;
    logic        rst;
    logic        mem_stop;
    logic        req_valid;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] ext_data;

    logic        req_ready, resp_valid, resp_misalign, ext_ram_wen;
    logic [63:0] resp_rdata, ext_ram_write_data;
    logic [31:0] ext_addr;
    logic [7:0]  ext_ram_be_n;

    logic        nc_ready, nc_resp_valid, nc_misalign, nc_wen;
    logic [63:0] nc_rdata, nc_wd;
    logic [31:0] nc_addr;
    logic [7:0]  nc_be;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem [8];
    int          wr_cnt;

    lsu_ext_port dut (
        .clk(clk), .rst(rst), .mem_stop(mem_stop),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .ext_addr(ext_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_wen(ext_ram_wen), .ext_ram_write_data(ext_ram_write_data),
        .ext_data(ext_data)
    );

    lsu_ext_port #(.ADDR_W(32), .MISALIGN_CHK(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .mem_stop(mem_stop),
        .req_valid(req_valid), .req_ready(nc_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(nc_resp_valid), .resp_rdata(nc_rdata),
        .resp_misalign(nc_misalign), .ext_addr(nc_addr), .ext_ram_be_n(nc_be),
        .ext_ram_wen(nc_wen), .ext_ram_write_data(nc_wd),
        .ext_data(ext_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest(input logic [7:0] be);
        for (int b = 0; b < 8; b++) begin
            if (be[b]) return b;
        end
        return 0;
    endfunction

    // RAM model driven only by the checked instance; data right-aligned on both sides.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
            mem[0]   <= 64'h0000_0000_0000_8500;
            ext_data <= 64'd0;
        end else if (!mem_stop && ext_ram_be_n != 8'h00) begin
            if (ext_ram_wen) begin
                for (int b = 0; b < 8; b++) begin
                    if (ext_ram_be_n[b])
                        mem[ext_addr[5:3]][8*b +: 8] <= ext_ram_write_data[8*(b - lowest(ext_ram_be_n)) +: 8];
                end
                wr_cnt <= wr_cnt + 1;
            end else begin
                ext_data <= mem[ext_addr[5:3]] >> (8 * lowest(ext_ram_be_n));
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] wd;
        logic [63:0] rdata;
        int          lat;
        logic        mis;
        logic [7:0]  nc_be;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [7:0] be, input logic [63:0] wd,
                                input logic [63:0] rdata, input int lat, input logic mis,
                                input logic [7:0] nc_be);
        vec_t v;
        v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.be = be; v.wd = wd; v.rdata = rdata; v.lat = lat; v.mis = mis; v.nc_be = nc_be;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        req_valid    = 1'b1;
        req_wen      = v.wen;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    task automatic do_req(input vec_t v, input string nm);
        int          cyc, lat;
        logic        done, ndone, extra, mis, swen;
        logic [7:0]  sbe, snbe;
        logic [63:0] swd, rdata;
        logic [31:0] sad;
        cyc = 0; lat = 0; done = 0; ndone = 0; extra = 0; mis = 0; swen = 0;
        sbe = 0; snbe = 0; swd = 0; rdata = 0; sad = 0;
        @(negedge clk);
        drive_req(v);
        check({nm, " ready"}, {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        while (!(done && ndone) && cyc < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (ext_ram_be_n != 8'h00) begin
                sbe  |= ext_ram_be_n;
                swen |= ext_ram_wen;
                swd   = ext_ram_write_data;
                sad   = ext_addr;
            end
            snbe |= nc_be;
            if (nc_resp_valid) ndone = 1;
            if (resp_valid) begin
                if (done) extra = 1;
                else begin
                    done  = 1;
                    lat   = cyc;
                    mis   = resp_misalign;
                    rdata = resp_rdata;
                end
            end
        end
        @(negedge clk);
        check({nm, " latency"}, 64'(lat), 64'(v.lat));
        check({nm, " misalign"}, {63'd0, mis}, {63'd0, v.mis});
        check({nm, " rdata"}, rdata, v.rdata);
        check({nm, " be"}, {56'd0, sbe}, {56'd0, v.be});
        check({nm, " wen"}, {63'd0, swen}, {63'd0, v.wen && !v.mis});
        check({nm, " wdata"}, swd, v.wd);
        check({nm, " addr"}, {32'd0, sad}, {32'd0, (v.be != 8'h00) ? v.addr : 32'd0});
        check({nm, " nc_be"}, {56'd0, snbe}, {56'd0, v.nc_be});
        check({nm, " single pulse"}, {63'd0, extra | resp_valid}, 64'd0);
        check({nm, " ready after"}, {63'd0, req_ready}, 64'd1);
    endtask

    vec_t vecs [14];
    vec_t v;
    logic [7:0]  snap_be;
    logic [63:0] snap_wd;
    int          w0, seen;

    initial begin
        vecs[0]  = mk(0, 2'd0, 0, 32'h8000_0001, 64'd0, 8'h02, 64'd0, 64'hFFFF_FFFF_FFFF_FF85, 3, 0, 8'h02);
        vecs[1]  = mk(0, 2'd1, 1, 32'h8000_0000, 64'd0, 8'h03, 64'd0, 64'h0000_0000_0000_8500, 3, 0, 8'h03);
        vecs[2]  = mk(0, 2'd1, 0, 32'h8000_0000, 64'd0, 8'h03, 64'd0, 64'hFFFF_FFFF_FFFF_8500, 3, 0, 8'h03);
        vecs[3]  = mk(1, 2'd2, 0, 32'h8000_0004, 64'hDEAD_BEEF_1234_5678, 8'hF0,
                      64'h0000_0000_1234_5678, 64'd0, 2, 0, 8'hF0);
        vecs[4]  = mk(0, 2'd3, 0, 32'h8000_0000, 64'd0, 8'hFF, 64'd0, 64'h1234_5678_0000_8500, 3, 0, 8'hFF);
        vecs[5]  = mk(1, 2'd0, 0, 32'h8000_0007, 64'h0000_0000_0000_AAF0, 8'h80, 64'h0000_0000_0000_00F0,
                      64'd0, 2, 0, 8'h80);
        vecs[6]  = mk(0, 2'd2, 0, 32'h8000_0004, 64'd0, 8'hF0, 64'd0, 64'hFFFF_FFFF_F034_5678, 3, 0, 8'hF0);
        vecs[7]  = mk(0, 2'd2, 1, 32'h8000_0004, 64'd0, 8'hF0, 64'd0, 64'h0000_0000_F034_5678, 3, 0, 8'hF0);
        vecs[8]  = mk(0, 2'd2, 0, 32'h8000_0002, 64'd0, 8'h00, 64'd0, 64'd0, 1, 1, 8'h3C);
        vecs[9]  = mk(1, 2'd1, 0, 32'h8000_0003, 64'h0000_0000_0000_BEEF, 8'h00, 64'd0, 64'd0, 1, 1, 8'h18);
        vecs[10] = mk(1, 2'd3, 0, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF,
                      64'd0, 2, 0, 8'hFF);
        vecs[11] = mk(0, 2'd3, 0, 32'h8000_0008, 64'd0, 8'hFF, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 0, 8'hFF);
        vecs[12] = mk(0, 2'd0, 1, 32'h8000_000F, 64'd0, 8'h80, 64'd0, 64'h0000_0000_0000_0001, 3, 0, 8'h80);
        vecs[13] = mk(0, 2'd1, 0, 32'h8000_0008, 64'd0, 8'h03, 64'd0, 64'hFFFF_FFFF_FFFF_CDEF, 3, 0, 8'h03);

        rst = 1'b0; mem_stop = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 64'd0; wr_cnt = 0;
        #12;
        check("reset ready", {63'd0, req_ready}, 64'd1);
        check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset be", {56'd0, ext_ram_be_n}, 64'd0);
        check("reset wen", {63'd0, ext_ram_wen}, 64'd0);
        check("reset rdata", resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) do_req(vecs[i], $sformatf("v%0d", i));

        // Store stalled for three cycles while sitting in ISSUE.
        v = mk(1, 2'd2, 0, 32'h8000_0010, 64'h55AA_55AA_CAFE_F00D, 8'h0F, 64'h0000_0000_CAFE_F00D,
               64'd0, 2, 0, 8'h0F);
        @(negedge clk);
        drive_req(v);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("stall issue be", {56'd0, ext_ram_be_n}, 64'h0F);
        snap_be = ext_ram_be_n;
        snap_wd = ext_ram_write_data;
        w0 = wr_cnt;
        mem_stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d be", k), {56'd0, ext_ram_be_n}, {56'd0, snap_be});
            check($sformatf("stall%0d wdata", k), ext_ram_write_data, snap_wd);
            check($sformatf("stall%0d wen", k), {63'd0, ext_ram_wen}, 64'd1);
            check($sformatf("stall%0d resp", k), {63'd0, resp_valid}, 64'd0);
        end
        check("stall no write", 64'(wr_cnt), 64'(w0));
        mem_stop = 1'b0;
        @(negedge clk);
        check("stall resp", {63'd0, resp_valid}, 64'd1);
        check("stall one write", 64'(wr_cnt), 64'(w0 + 1));
        @(negedge clk);
        check("stall resp gone", {63'd0, resp_valid}, 64'd0);
        check("stall single write", 64'(wr_cnt), 64'(w0 + 1));
        v = mk(0, 2'd3, 0, 32'h8000_0010, 64'd0, 8'hFF, 64'd0, 64'h0000_0000_CAFE_F00D, 3, 0, 8'hFF);
        do_req(v, "stall readback");

        // Reset asserted while a load sits in CAPT.
        v = mk(0, 2'd3, 0, 32'h8000_0000, 64'd0, 8'hFF, 64'd0, 64'd0, 3, 0, 8'hFF);
        @(negedge clk);
        drive_req(v);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("capt resp", {63'd0, resp_valid}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst be", {56'd0, ext_ram_be_n}, 64'd0);
        check("rst wen", {63'd0, ext_ram_wen}, 64'd0);
        check("rst ready", {63'd0, req_ready}, 64'd1);
        check("rst rdata", resp_rdata, 64'd0);
        check("rst addr", {32'd0, ext_addr}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst no resp", 64'(seen), 64'd0);
        do_req(vecs[0], "post-reset lb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ext_port.md
Name: lsu_ext_port

Overview:
- Load/store unit sitting directly upstream of the data RAM's ext port. Accepts one memory request at a time from the MEM stage over a valid/ready handshake.
- Checks alignment, generates the 8-bit byte-enable mask, and drives the RAM ext-port signals.
- Sign/zero-extends returned load data and answers the pipeline with a single-cycle response pulse.
- Honours the global mem_stop stall exactly as the RAM does.

Parameters:
ADDR_W, 32, width of request/RAM address
MISALIGN_CHK, 1, 1 = misaligned requests are rejected with resp_misalign; 0 = check disabled, low bits ignored

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
mem_stop  in  1  global stall; freezes FSM and all registers when high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE and mem_stop low
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword
req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data, right-aligned (LSBs)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  extended load data; 0 for stores and misaligned requests
resp_misalign  out  1  qualifies resp_valid; request not performed
ext_addr  out  ADDR_W  to RAM
ext_ram_be_n  out  8  byte enables to RAM (active-high despite the name)
ext_ram_wen  out  1  RAM write strobe
ext_ram_write_data  out  64  right-aligned store data; RAM shifts by lowest enabled byte
ext_data  in  64  RAM read data, right-aligned, valid the cycle after the RAM samples

Behaviour:
- Reset (rst low, async): state=IDLE. All outputs 0 except req_ready=1. Any in-flight access is dropped; ext_ram_wen falls immediately.
- FSM states: IDLE, ISSUE, CAPT, RESP. Every transition and register update is gated by !mem_stop. While mem_stop=1, all state holds and outputs hold.
- IDLE:
  - Handshake: req_valid && req_ready at a rising edge.
  - On handshake, latch wen/size/unsigned/addr/wdata and compute be = base << addr[2:0]. Base: size0=0x01, size1=0x03, size2=0x0F, size3=0xFF.
  - Misaligned (MISALIGN_CHK=1): size1 && addr[0]; size2 && addr[1:0]!=0; size3 && addr[2:0]!=0. Misaligned -> RESP with misalign flag; no RAM access.
  - Otherwise -> ISSUE.
- ISSUE:
  - Drive ext_addr=latched addr, ext_ram_be_n=be, ext_ram_wen=latched wen.
  - Drive ext_ram_write_data = wdata masked to size (upper bytes 0).
  - Store -> RESP. Load -> CAPT.
- CAPT:
  - ext_ram_wen=0, ext_ram_be_n=0.
  - At the edge, register resp_rdata from ext_data per size/unsigned: sign-extend from bit 7/15/31, zero-extend when unsigned; dword passes through.
  - -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. resp_misalign=1 only for rejected requests. resp_rdata holds its value until the next response.
- Outside ISSUE: ext_ram_wen=0 and ext_ram_be_n=0, so the RAM never writes spuriously.
- Latency from handshake edge: load resp_valid high in the 3rd cycle; store in 2nd; misaligned in 1st. mem_stop cycles add 1:1.
- Back-to-back throughput: next request accepted in the cycle after RESP (req_ready high again in IDLE).
- req_valid held high during RESP is not accepted until IDLE.
- mem_stop asserted during ISSUE: outputs held, RAM also frozen, write performed once after release.
- Boundary addresses: addr[2:0]=7 byte access uses be=0x80. Dword at addr[2:0]=0 uses be=0xFF. Bits above the RAM index pass through unchanged.

Test Plan:
- Load byte signed: RAM word at 0x80000000 = 0x0000_0000_0000_8500, req lb addr 0x80000001 -> be=0x02; resp_rdata=0xFFFF_FFFF_FFFF_FF85, resp_valid 3 cycles after accept.
- Load half unsigned: same word, lhu addr 0x80000000 -> be=0x03, resp_rdata=0x0000_0000_0000_8500.
- Store word at offset 4: sw addr 0x80000004 wdata 0xDEAD_BEEF_1234_5678 -> one ISSUE cycle with be=0xF0, wen=1, write_data=0x0000_0000_1234_5678; resp_valid 2 cycles after accept; reload ld gives 0x1234_5678_xxxx_xxxx.
- Misaligned: lw addr 0x80000002 -> resp_valid+resp_misalign next cycle, ext_ram_wen/be never asserted, resp_rdata=0; MISALIGN_CHK=0 run issues be=0x3C shifted form instead.
- Stall: mem_stop high 3 cycles while in ISSUE on a store -> ext outputs stable, single write after release, resp_valid delayed by exactly 3 cycles.
- Reset mid-load: rst low during CAPT -> outputs zero immediately, req_ready=1 after release, no resp_valid emitted; a following lb completes normally.
